// File: rtl/gru_ctrl_pkg.sv
// rtl/gru_ctrl_pkg.sv - shared types and defaults for the GRU sequence controller
package gru_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } gru_state_t;

    localparam int GRU_SEQ_LEN      = 15;
    localparam int GRU_CELL_LATENCY = 18;

endpackage

// File: rtl/gru_seq_ctrl_if.sv
// rtl/gru_seq_ctrl_if.sv - x input and y output handshake bundle of the GRU sequence controller
interface gru_seq_ctrl_if #(
    parameter int x_SIZE = 6,
    parameter int h_SIZE = 120,
    parameter int WIDTH  = 16
) ();

    logic                               x_valid;
    logic                               x_ready;
    logic signed [x_SIZE-1:0][WIDTH-1:0] x_data;
    logic                               y_valid;
    logic                               y_ready;
    logic signed [h_SIZE-1:0][WIDTH-1:0] y_data;

    modport master (
        output x_valid, x_data, y_ready,
        input  x_ready, y_valid, y_data
    );

    modport slave (
        input  x_valid, x_data, y_ready,
        output x_ready, y_valid, y_data
    );

endinterface

// File: rtl/gru_seq_ctrl.sv
// rtl/gru_seq_ctrl.sv - steps an external GRU cell through SEQ_LEN timesteps and presents the final hidden state
module gru_seq_ctrl
    import gru_ctrl_pkg::*;
#(
    parameter int x_SIZE       = 6,
    parameter int h_SIZE       = 120,
    parameter int WIDTH        = 16,
    parameter int SEQ_LEN      = GRU_SEQ_LEN,
    parameter int CELL_LATENCY = GRU_CELL_LATENCY
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                flush,
    gru_seq_ctrl_if.slave                       xy,
    output logic signed [x_SIZE-1:0][WIDTH-1:0] cell_x,
    output logic signed [h_SIZE-1:0][WIDTH-1:0] cell_h_prev,
    input  logic signed [h_SIZE-1:0][WIDTH-1:0] cell_h,
    output logic [3:0]                          step_idx,
    output logic                                busy
);

    localparam int CNT_W = $clog2(CELL_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CELL_LATENCY - 1);
    localparam logic [3:0]       STEP_LAST = 4'(SEQ_LEN - 1);

    gru_state_t                          state, state_nxt;
    logic [CNT_W-1:0]                    run_cnt;
    logic signed [h_SIZE-1:0][WIDTH-1:0] h_reg;

    assign xy.x_ready = (state == IDLE);
    assign xy.y_valid = (state == OUT);
    assign xy.y_data  = h_reg;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (xy.x_valid) state_nxt = RUN;
            RUN:  if (run_cnt == CNT_LAST) state_nxt = (step_idx == STEP_LAST) ? OUT : IDLE;
            OUT:  if (xy.y_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // flush overrides every transition, including capture and y handshake
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step_idx    <= '0;
            run_cnt     <= '0;
            cell_x      <= '0;
            cell_h_prev <= '0;
            h_reg       <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                step_idx <= '0;
                run_cnt  <= '0;
            end else begin
                unique case (state)
                    IDLE: if (xy.x_valid) begin
                        cell_x      <= xy.x_data;
                        cell_h_prev <= (step_idx == 4'd0) ? '0 : h_reg;
                        run_cnt     <= '0;
                    end
                    RUN: begin
                        run_cnt <= run_cnt + CNT_W'(1);
                        // cell inputs have now been stable for CELL_LATENCY cycles
                        if (run_cnt == CNT_LAST) begin
                            h_reg <= cell_h;
                            if (step_idx != STEP_LAST) step_idx <= step_idx + 4'd1;
                        end
                    end
                    OUT: if (xy.y_ready) step_idx <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// tb/tb_gru_seq_ctrl.sv - randomized scoreboard bench for gru_seq_ctrl with a latency-accurate cell model
module tb_gru_seq_ctrl;
    import gru_ctrl_pkg::*;

    localparam int XS = 6;
    localparam int HS = 120;
    localparam int W  = 16;
    localparam int SL = 15;
    localparam int L  = 18;

    typedef logic [XS-1:0][W-1:0] xvec_t;
    typedef logic [HS-1:0][W-1:0] hvec_t;

    logic  clk = 1'b0;
    logic  reset;
    logic  flush;
    xvec_t cell_x;
    hvec_t cell_h_prev;
    hvec_t cell_h;
    logic [3:0] step_idx;
    logic  busy;

    always #5 clk = ~clk;

    gru_seq_ctrl_if #(.x_SIZE(XS), .h_SIZE(HS), .WIDTH(W)) bus ();

    gru_seq_ctrl #(
        .x_SIZE(XS), .h_SIZE(HS), .WIDTH(W), .SEQ_LEN(SL), .CELL_LATENCY(L)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush), .xy(bus.slave),
        .cell_x(cell_x), .cell_h_prev(cell_h_prev), .cell_h(cell_h),
        .step_idx(step_idx), .busy(busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] e);
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, got, e);
        end
    endtask

    task automatic chk_h(input string nm, input hvec_t got, input logic [W-1:0] e);
        int bad;
        bad = -1;
        for (int i = 0; i < HS; i++) if (bad < 0 && got[i] !== e) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s: element %0d is %h, required %h", nm, bad, got[bad], e);
        end
    endtask

    task automatic chk_x(input string nm, input xvec_t got, input xvec_t e);
        n_cmp++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, got, e);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting, required event never seen", nm);
    endtask

    // Cell model: correct sum only once inputs have been stable for L cycles, garbage before that
    int    stab = 0;
    xvec_t snap_x;
    hvec_t snap_h;
    always @(negedge clk) begin
        if (cell_x !== snap_x || cell_h_prev !== snap_h) begin
            snap_x = cell_x;
            snap_h = cell_h_prev;
            stab   = 0;
        end else begin
            stab++;
        end
        for (int i = 0; i < HS; i++)
            cell_h[i] = (stab >= L - 1) ? cell_h_prev[i] + cell_x[0] : (16'hBAD0 ^ 16'(i));
    end

    // Scoreboard: final hidden value of each completed sequence is the wrapped sum of its x[0]s
    logic [W-1:0] exp_q[$];
    int           m_step = 0;
    logic [W-1:0] m_acc = '0;
    bit           chk_prev = 0;
    logic [W-1:0] prev_hp;
    xvec_t        prev_x;
    bit           spacing_on = 0;
    int           cyc = 0;
    int           last_acc = 0;
    int           n_acc = 0;
    int           n_y = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            exp_q.delete();
            m_step   = 0;
            m_acc    = '0;
            chk_prev = 0;
        end else begin
            if (chk_prev) begin
                chk_x("cell_x", cell_x, prev_x);
                chk_h("cell_h_prev", cell_h_prev, prev_hp);
                chk("busy_run", busy, 1);
                chk_prev = 0;
            end
            if (bus.y_valid !== 1'b0) begin
                chk("x_ready_in_out", bus.x_ready, 0);
                chk("step_idx_out", step_idx, SL - 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_y_valid: y_valid=%b with no completed sequence", bus.y_valid);
                end else begin
                    chk_h("y_data", bus.y_data, exp_q[0]);
                end
            end
            if (flush) begin
                exp_q.delete();
                m_step = 0;
            end else begin
                if (bus.y_valid === 1'b1 && bus.y_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front());
                    n_y++;
                end
                if (bus.x_valid && bus.x_ready === 1'b1) begin
                    chk("step_idx_accept", step_idx, m_step);
                    if (m_step == 0) m_acc = '0;
                    prev_hp  = m_acc;
                    prev_x   = bus.x_data;
                    chk_prev = 1;
                    if (spacing_on && m_step > 0) chk("accept_spacing", cyc - last_acc, L + 1);
                    last_acc = cyc;
                    m_acc    = m_acc + bus.x_data[0];
                    m_step++;
                    n_acc++;
                    if (m_step == SL) begin
                        exp_q.push_back(m_acc);
                        m_step = 0;
                    end
                end
            end
        end
    end

    task automatic send_x(input logic [W-1:0] x0);
        int k;
        xvec_t v;
        for (int i = 0; i < XS; i++) v[i] = W'($urandom);
        v[0] = x0;
        bus.x_data  = v;
        bus.x_valid = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.x_ready === 1'b1) break;
        end
        if (k == 200) timeout("x_accept");
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
    endtask

    task automatic run_steps(input int n, input bit fixed_one, input bit gaps);
        for (int s = 0; s < n; s++) begin
            if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            send_x(fixed_one ? 16'd1 : W'($urandom));
        end
    endtask

    task automatic wait_yvalid();
        int k;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.y_valid === 1'b1) break;
        end
        if (k == 200) timeout("y_valid");
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy === 1'b0) break;
        end
        if (k == 400) timeout("idle");
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        flush       = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.y_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_x_ready", bus.x_ready, 1);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_step_idx", step_idx, 0);
        chk_x("rst_cell_x", cell_x, '0);
        chk_h("rst_cell_h_prev", cell_h_prev, '0);
        chk_h("rst_y_data", bus.y_data, '0);
        @(posedge clk);
        #1;

        // full sequence of ones, consumer always ready, back-to-back x
        bus.y_ready = 1'b1;
        spacing_on  = 1;
        run_steps(SL, 1, 0);
        wait_idle();
        spacing_on = 0;
        chk("seq1_y_count", n_y, 1);
        chk("seq1_accepts", n_acc, SL);

        // second sequence with back-pressure held for 40 cycles
        bus.y_ready = 1'b0;
        run_steps(SL, 1, 1);
        wait_yvalid();
        repeat (40) @(negedge clk);
        @(posedge clk);
        #1;
        bus.y_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_x_ready", bus.x_ready, 1);
        chk("release_y_valid", bus.y_valid, 0);
        chk("seq2_y_count", n_y, 2);
        @(posedge clk);
        #1;

        // flush during the RUN phase of step 7
        run_steps(8, 1, 0);
        repeat (5) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        chk("flush_step_idx", step_idx, 0);
        chk("flush_x_ready", bus.x_ready, 1);
        @(posedge clk);
        #1;
        run_steps(SL, 1, 0);
        wait_idle();
        chk("seq3_y_count", n_y, 3);

        // flush coincident with x_valid in IDLE: nothing accepted
        bus.x_data  = '1;
        bus.x_valid = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        bus.x_valid = 1'b0;
        flush       = 1'b0;
        @(negedge clk);
        chk("flush_x_busy", busy, 0);
        chk("flush_x_step", step_idx, 0);
        @(posedge clk);
        #1;

        // random sequences with random x[0] and random consumer delay
        for (int r = 0; r < 3; r++) begin
            bus.y_ready = 1'b0;
            run_steps(SL, 0, 1);
            wait_yvalid();
            repeat ($urandom_range(0, 6)) @(negedge clk);
            @(posedge clk);
            #1;
            bus.y_ready = 1'b1;
            wait_idle();
        end
        chk("rand_y_count", n_y, 6);

        // reset while holding the final output
        bus.y_ready = 1'b0;
        run_steps(SL, 1, 0);
        wait_yvalid();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_y_valid", bus.y_valid, 0);
        chk("rst_out_busy", busy, 0);
        chk("rst_out_x_ready", bus.x_ready, 1);
        chk("rst_out_step_idx", step_idx, 0);
        chk_x("rst_out_cell_x", cell_x, '0);
        chk_h("rst_out_cell_h_prev", cell_h_prev, '0);
        chk_h("rst_out_y_data", bus.y_data, '0);
        bus.y_ready = 1'b1;
        repeat (40) @(negedge clk);
        chk("final_y_count", n_y, 6);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
